tri_fetch: RTL and testbench

- Raster-domain stage directly downstream of the raster memory.
- Walks instances 0..num_inst-1; for each it reads the instance transform and vert/tri buffer descriptors, iterates the instance's triangles, fetches the three vertices of each, and emits one fully assembled triangle (3 vertex_t + transform_t) per valid/ready handshake to the transform stage.
- Single outstanding memory access; purely sequential fetch, no read-ahead.

---
 rtl/tri_fetch_pkg.sv | 29 ++
 rtl/vertex_pkg.sv | 19 +
 rtl/tri_fetch_if.sv | 27 ++
 rtl/tri_fetch_wait_ctr.sv | 29 ++
 rtl/tri_fetch.sv | 214 +++++++++++++++++++++
 tb/tb_tri_fetch.sv | 304 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/tri_fetch_pkg.sv
// Triangle fetch FSM state encoding and default memory latencies.
// Pure definitions, no logic.
// Latency defaults describe the descriptor and raster memory read paths.
package tri_fetch_pkg;

    localparam int DESC_LAT_DEF = 3;
    localparam int MEM_LAT_DEF  = 2;
    localparam int WAIT_CW      = 4;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DESC      = 4'd1,
        ST_TRI       = 4'd2,
        ST_V0        = 4'd3,
        ST_V1        = 4'd4,
        ST_V2        = 4'd5,
        ST_EMIT      = 4'd6,
        ST_NEXT_TRI  = 4'd7,
        ST_NEXT_INST = 4'd8,
        ST_FIN       = 4'd9
    } fetch_state_e;

    // States that hold while a memory read settles.
    function automatic logic is_wait_state(input fetch_state_e s);
        return (s == ST_DESC) || (s == ST_TRI) || (s == ST_V0) ||
               (s == ST_V1)   || (s == ST_V2);
    endfunction

endpackage

// File: rtl/vertex_pkg.sv
// Shared geometry types for the raster domain.
// Pure type definitions, no logic.
// Vertex and per-instance transform payloads carried between stages.
package vertex_pkg;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } vertex_t;

    typedef struct packed {
        logic [15:0] tx;
        logic [15:0] ty;
        logic [15:0] tz;
        logic [15:0] scale;
    } transform_t;

endpackage

// File: rtl/tri_fetch_if.sv
// Assembled-triangle valid/ready bus from the fetch stage to the transform stage.
// No logic; payload is registered by the producer.
// Producer holds valid and payload stable until ready is seen.
interface tri_fetch_if #(
    parameter int INST_AW = 8
);
    import vertex_pkg::*;

    logic               out_valid;
    logic               out_ready;
    vertex_t            out_v0;
    vertex_t            out_v1;
    vertex_t            out_v2;
    transform_t         out_transform;
    logic [INST_AW-1:0] out_inst_id;

    modport master (
        output out_valid, out_v0, out_v1, out_v2, out_transform, out_inst_id,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_v0, out_v1, out_v2, out_transform, out_inst_id,
        output out_ready
    );

endinterface

// File: rtl/tri_fetch_wait_ctr.sv
// Loadable down-counter that paces every memory wait state of the fetch FSM.
// expire rises load_val cycles after a load (cycle after load counts as first).
// No backpressure; reloads take priority over counting.
module tri_fetch_wait_ctr #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_raster_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          expire
);

    logic [CW-1:0] cnt;

    // Load on wait-state entry, then count down and park at zero.
    always_ff @(posedge clk) begin
        if (!rst_raster_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/tri_fetch.sv
// Walks instances, fetches descriptors, triangle indices and vertices, emits assembled triangles.
// Each read state lasts LAT+1 cycles; one triangle per >= 4*(MEM_LAT+1)+2 cycles.
// Output held in EMIT until out_ready; consumer may stall indefinitely.
module tri_fetch
    import vertex_pkg::*;
    import tri_fetch_pkg::*;
#(
    parameter int MAX_INST = 256,
    parameter int MAX_VERT = 8192,
    parameter int MAX_TRI  = 8192,
    parameter int VIDX_W   = 12,
    parameter int TIDX_W   = 12,
    parameter int DESC_LAT = DESC_LAT_DEF,
    parameter int MEM_LAT  = MEM_LAT_DEF,
    localparam int INST_AW = $clog2(MAX_INST),
    localparam int VERT_AW = $clog2(MAX_VERT),
    localparam int TRI_AW  = $clog2(MAX_TRI)
) (
    input  logic                clk,
    input  logic                rst_raster_n,
    input  logic                start,
    input  logic [INST_AW:0]    num_inst,
    output logic                busy,
    output logic                done,
    output logic                idx_err,
    output logic [INST_AW-1:0]  inst_id_rd,
    output logic [TRI_AW-1:0]   tri_addr_rd,
    output logic [VERT_AW-1:0]  vert_addr_rd,
    input  logic [VERT_AW-1:0]  vert_base_in,
    input  logic [VIDX_W-1:0]   vert_count_in,
    input  logic [TRI_AW-1:0]   tri_base_in,
    input  logic [TIDX_W-1:0]   tri_count_in,
    input  logic [3*VIDX_W-1:0] idx_tri_in,
    input  vertex_t             vert_in,
    input  transform_t          transform_in,
    tri_fetch_if.master         out_if
);

    localparam logic [INST_AW:0]  INST_ONE = 1;
    localparam logic [TIDX_W-1:0] TRI_ONE  = 1;

    fetch_state_e state_q, state_d;

    logic                wait_exp;
    logic                wait_load;
    logic [WAIT_CW-1:0]  wait_val;

    logic [INST_AW:0]    inst_ctr, num_q, inst_nxt;
    logic [TIDX_W-1:0]   tri_ctr, tri_count_q, tri_nxt;
    logic [VERT_AW-1:0]  vert_base_q;
    logic [VIDX_W-1:0]   vert_count_q;
    logic [TRI_AW-1:0]   tri_base_q;
    logic [VIDX_W-1:0]   i0_in, i1_in, i2_in, i1_q, i2_q;
    logic                idx_bad, last_tri, last_inst, out_hs;

    logic                out_valid_q;
    vertex_t             out_v0_q, out_v1_q, out_v2_q;
    transform_t          out_xf_q;
    logic [INST_AW-1:0]  out_id_q;

    assign {i0_in, i1_in, i2_in} = idx_tri_in;
    assign idx_bad   = (i0_in >= vert_count_q) || (i1_in >= vert_count_q) ||
                       (i2_in >= vert_count_q);
    assign inst_nxt  = inst_ctr + INST_ONE;
    assign tri_nxt   = tri_ctr + TRI_ONE;
    assign last_inst = (inst_nxt == num_q);
    assign last_tri  = (tri_nxt == tri_count_q);
    assign out_hs    = out_valid_q && out_if.out_ready;

    tri_fetch_wait_ctr #(.CW(WAIT_CW)) u_wait (
        .clk          (clk),
        .rst_raster_n (rst_raster_n),
        .load         (wait_load),
        .load_val     (wait_val),
        .expire       (wait_exp)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_raster_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; wait states advance only once their read has settled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = (num_inst == '0) ? ST_FIN : ST_DESC;
            ST_DESC:      if (wait_exp) state_d = (tri_count_in == '0) ? ST_NEXT_INST : ST_TRI;
            ST_TRI:       if (wait_exp) state_d = idx_bad ? ST_NEXT_TRI : ST_V0;
            ST_V0:        if (wait_exp) state_d = ST_V1;
            ST_V1:        if (wait_exp) state_d = ST_V2;
            ST_V2:        if (wait_exp) state_d = ST_EMIT;
            ST_EMIT:      if (out_hs) state_d = ST_NEXT_TRI;
            ST_NEXT_TRI:  state_d = last_tri ? ST_NEXT_INST : ST_TRI;
            ST_NEXT_INST: state_d = last_inst ? ST_FIN : ST_DESC;
            ST_FIN:       state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Arm the wait counter on entry to any read state with the matching latency.
    always_comb begin
        wait_load = (state_d != state_q) && is_wait_state(state_d);
        wait_val  = (state_d == ST_DESC) ? WAIT_CW'(DESC_LAT) : WAIT_CW'(MEM_LAT);
    end

    // Registered datapath: addresses change only on state entry, data captured on expiry.
    always_ff @(posedge clk) begin
        if (!rst_raster_n) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            idx_err      <= 1'b0;
            inst_id_rd   <= '0;
            tri_addr_rd  <= '0;
            vert_addr_rd <= '0;
            inst_ctr     <= '0;
            num_q        <= '0;
            tri_ctr      <= '0;
            tri_count_q  <= '0;
            vert_base_q  <= '0;
            vert_count_q <= '0;
            tri_base_q   <= '0;
            i1_q         <= '0;
            i2_q         <= '0;
            out_valid_q  <= 1'b0;
            out_v0_q     <= '0;
            out_v1_q     <= '0;
            out_v2_q     <= '0;
            out_xf_q     <= '0;
            out_id_q     <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        idx_err  <= 1'b0;
                        inst_ctr <= '0;
                        num_q    <= num_inst;
                        busy     <= 1'b1;
                        if (num_inst != '0) inst_id_rd <= '0;
                    end
                end
                ST_DESC: begin
                    if (wait_exp) begin
                        vert_base_q  <= vert_base_in;
                        vert_count_q <= vert_count_in;
                        tri_base_q   <= tri_base_in;
                        tri_count_q  <= tri_count_in;
                        out_xf_q     <= transform_in;
                        out_id_q     <= inst_ctr[INST_AW-1:0];
                        if (tri_count_in != '0) begin
                            tri_ctr     <= '0;
                            tri_addr_rd <= tri_base_in;
                        end
                    end
                end
                ST_TRI: begin
                    if (wait_exp) begin
                        i1_q <= i1_in;
                        i2_q <= i2_in;
                        if (idx_bad) idx_err <= 1'b1;
                        else vert_addr_rd <= vert_base_q + VERT_AW'(i0_in);
                    end
                end
                ST_V0: begin
                    if (wait_exp) begin
                        out_v0_q     <= vert_in;
                        vert_addr_rd <= vert_base_q + VERT_AW'(i1_q);
                    end
                end
                ST_V1: begin
                    if (wait_exp) begin
                        out_v1_q     <= vert_in;
                        vert_addr_rd <= vert_base_q + VERT_AW'(i2_q);
                    end
                end
                ST_V2: begin
                    if (wait_exp) begin
                        out_v2_q    <= vert_in;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (out_hs) out_valid_q <= 1'b0;
                end
                ST_NEXT_TRI: begin
                    tri_ctr <= tri_nxt;
                    if (!last_tri) tri_addr_rd <= tri_base_q + TRI_AW'(tri_nxt);
                end
                ST_NEXT_INST: begin
                    inst_ctr <= inst_nxt;
                    if (!last_inst) inst_id_rd <= inst_nxt[INST_AW-1:0];
                end
                ST_FIN: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_if.out_valid     = out_valid_q;
    assign out_if.out_v0        = out_v0_q;
    assign out_if.out_v1        = out_v1_q;
    assign out_if.out_v2        = out_v2_q;
    assign out_if.out_transform = out_xf_q;
    assign out_if.out_inst_id   = out_id_q;

endmodule

// File: tb/tb_tri_fetch.sv
// Directed bench for tri_fetch with latency-accurate descriptor and memory models.
// Descriptor path delays DESC_LAT cycles, triangle/vertex RAM paths MEM_LAT cycles.
// Consumer ready is driven directly by the stimulus sequence.
module tb_tri_fetch;
    import vertex_pkg::*;

    localparam int INST_AW = 8;
    localparam int VERT_AW = 13;
    localparam int TRI_AW  = 13;
    localparam int VIDX_W  = 12;
    localparam int TIDX_W  = 12;

    localparam transform_t XF0 = 64'h1111_2222_3333_4444;
    localparam transform_t XF1 = 64'h5555_6666_7777_8888;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_raster_n;
    logic                start;
    logic [INST_AW:0]    num_inst;
    logic                busy, done, idx_err;
    logic [INST_AW-1:0]  inst_id_rd;
    logic [TRI_AW-1:0]   tri_addr_rd;
    logic [VERT_AW-1:0]  vert_addr_rd;
    logic [VERT_AW-1:0]  vert_base_in;
    logic [VIDX_W-1:0]   vert_count_in;
    logic [TRI_AW-1:0]   tri_base_in;
    logic [TIDX_W-1:0]   tri_count_in;
    logic [3*VIDX_W-1:0] idx_tri_in;
    vertex_t             vert_in;
    transform_t          transform_in;

    tri_fetch_if #(.INST_AW(INST_AW)) oif ();

    tri_fetch dut (
        .clk           (clk),
        .rst_raster_n  (rst_raster_n),
        .start         (start),
        .num_inst      (num_inst),
        .busy          (busy),
        .done          (done),
        .idx_err       (idx_err),
        .inst_id_rd    (inst_id_rd),
        .tri_addr_rd   (tri_addr_rd),
        .vert_addr_rd  (vert_addr_rd),
        .vert_base_in  (vert_base_in),
        .vert_count_in (vert_count_in),
        .tri_base_in   (tri_base_in),
        .tri_count_in  (tri_count_in),
        .idx_tri_in    (idx_tri_in),
        .vert_in       (vert_in),
        .transform_in  (transform_in),
        .out_if        (oif)
    );

    // Memory contents and latency pipelines
    logic [VERT_AW-1:0]  d_vbase [0:255];
    logic [VIDX_W-1:0]   d_vcnt  [0:255];
    logic [TRI_AW-1:0]   d_tbase [0:255];
    logic [TIDX_W-1:0]   d_tcnt  [0:255];
    transform_t          d_xf    [0:255];
    logic [3*VIDX_W-1:0] tri_mem [0:8191];

    logic [INST_AW-1:0] ip1, ip2, ip3;
    logic [TRI_AW-1:0]  tp1, tp2;
    logic [VERT_AW-1:0] vp1, vp2;

    function automatic vertex_t vfn(input logic [VERT_AW-1:0] a);
        vertex_t v;
        v.x = {3'b000, a};
        v.y = {3'b000, a} ^ 16'hA5A5;
        v.z = {3'b000, a} + 16'h0100;
        return v;
    endfunction

    always @(posedge clk) begin
        ip1 <= inst_id_rd;   ip2 <= ip1; ip3 <= ip2;
        tp1 <= tri_addr_rd;  tp2 <= tp1;
        vp1 <= vert_addr_rd; vp2 <= vp1;
    end

    assign vert_base_in  = d_vbase[ip3];
    assign vert_count_in = d_vcnt[ip3];
    assign tri_base_in   = d_tbase[ip3];
    assign tri_count_in  = d_tcnt[ip3];
    assign transform_in  = d_xf[ip3];
    assign idx_tri_in    = tri_mem[tp2];
    assign vert_in       = vfn(vp2);

    // Event monitors
    int checks = 0, failures = 0;
    int done_cnt = 0, hs_cnt = 0, hs_at_done = 0;

    always @(posedge clk)
        if (oif.out_valid === 1'b1 && oif.out_ready === 1'b1) hs_cnt <= hs_cnt + 1;

    always @(negedge clk)
        if (done === 1'b1) begin
            done_cnt   <= done_cnt + 1;
            hs_at_done <= hs_cnt;
        end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_inst(input int i, input logic [VERT_AW-1:0] vb, input logic [VIDX_W-1:0] vc,
                            input logic [TRI_AW-1:0] tb, input logic [TIDX_W-1:0] tc, input transform_t xf);
        d_vbase[i] = vb; d_vcnt[i] = vc; d_tbase[i] = tb; d_tcnt[i] = tc; d_xf[i] = xf;
    endtask

    task automatic do_start(input int n);
        num_inst = (INST_AW+1)'(n);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic get_tri(input string tag, input logic [VERT_AW-1:0] a0, a1, a2,
                           input transform_t xf, input logic [INST_AW-1:0] id);
        bit got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (oif.out_valid === 1'b1) got = 1'b1;
        end
        chk({tag, "_valid"}, 128'(got), 128'(1));
        if (got) begin
            chk({tag, "_v0"}, 128'(oif.out_v0), 128'(vfn(a0)));
            chk({tag, "_v1"}, 128'(oif.out_v1), 128'(vfn(a1)));
            chk({tag, "_v2"}, 128'(oif.out_v2), 128'(vfn(a2)));
            chk({tag, "_xf"}, 128'(oif.out_transform), 128'(xf));
            chk({tag, "_id"}, 128'(oif.out_inst_id), 128'(id));
        end
    endtask

    task automatic wait_idle(input string tag);
        bit idle = 1'b0;
        for (int i = 0; i < 400 && !idle; i++) begin
            @(negedge clk);
            if (busy === 1'b0) idle = 1'b1;
        end
        chk({tag, "_idle"}, 128'(idle), 128'(1));
        @(negedge clk);
    endtask

    function automatic logic [255:0] snap_now();
        return 256'({oif.out_v0, oif.out_v1, oif.out_v2, oif.out_transform, oif.out_inst_id,
                     vert_addr_rd, tri_addr_rd, inst_id_rd, oif.out_valid});
    endfunction

    initial begin
        int d0, h0;
        bit ok, stable;
        logic [255:0] snap;

        rst_raster_n  = 1'b0;
        start         = 1'b0;
        num_inst      = '0;
        oif.out_ready = 1'b0;
        set_inst(0, 13'd100, 12'd10, 13'd0, 12'd1, XF0);
        set_inst(1, 13'd300, 12'd8, 13'd20, 12'd3, XF1);
        tri_mem[0]  = {12'd0, 12'd1, 12'd2};
        tri_mem[10] = {12'd0, 12'd1, 12'd2};
        tri_mem[11] = {12'd3, 12'd4, 12'd5};
        tri_mem[20] = {12'd7, 12'd6, 12'd5};
        tri_mem[21] = {12'd1, 12'd3, 12'd5};
        tri_mem[22] = {12'd2, 12'd2, 12'd0};
        tri_mem[30] = {12'd3, 12'd0, 12'd1};
        tri_mem[40] = {12'd0, 12'd5, 12'd1};
        tri_mem[41] = {12'd3, 12'd3, 12'd3};
        repeat (4) @(negedge clk);

        // Reset state
        chk("rst_ctl",  128'({busy, done, idx_err, oif.out_valid}), 128'(0));
        chk("rst_addr", 128'({inst_id_rd, tri_addr_rd, vert_addr_rd}), 128'(0));
        chk("rst_v01",  128'({oif.out_v0, oif.out_v1}), 128'(0));
        chk("rst_v2xf", 128'({oif.out_v2, oif.out_transform, oif.out_inst_id}), 128'(0));
        rst_raster_n = 1'b1;
        @(negedge clk);

        // Single triangle, single instance
        oif.out_ready = 1'b1;
        d0 = done_cnt;
        do_start(1);
        get_tri("t1", 13'd100, 13'd101, 13'd102, XF0, 8'd0);
        wait_idle("t1");
        chk("t1_done", 128'(done_cnt - d0), 128'(1));

        // Two instances, 2 + 3 triangles
        set_inst(0, 13'd200, 12'd8, 13'd10, 12'd2, XF0);
        set_inst(1, 13'd300, 12'd8, 13'd20, 12'd3, XF1);
        d0 = done_cnt; h0 = hs_cnt;
        do_start(2);
        get_tri("t2a", 13'd200, 13'd201, 13'd202, XF0, 8'd0);
        get_tri("t2b", 13'd203, 13'd204, 13'd205, XF0, 8'd0);
        get_tri("t2c", 13'd307, 13'd306, 13'd305, XF1, 8'd1);
        get_tri("t2d", 13'd301, 13'd303, 13'd305, XF1, 8'd1);
        get_tri("t2e", 13'd302, 13'd302, 13'd300, XF1, 8'd1);
        wait_idle("t2");
        chk("t2_hs",      128'(hs_cnt - h0), 128'(5));
        chk("t2_done",    128'(done_cnt - d0), 128'(1));
        chk("t2_hs_done", 128'(hs_at_done - h0), 128'(5));

        // Consumer stall for 20 cycles in EMIT
        set_inst(0, 13'd100, 12'd10, 13'd0, 12'd1, XF0);
        oif.out_ready = 1'b0;
        d0 = done_cnt; h0 = hs_cnt;
        do_start(1);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (oif.out_valid === 1'b1) ok = 1'b1;
        end
        chk("t3_valid", 128'(ok), 128'(1));
        chk("t3_vaddr", 128'(vert_addr_rd), 128'(102));
        snap = snap_now();
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (snap_now() !== snap) stable = 1'b0;
        end
        chk("t3_stable",   128'(stable), 128'(1));
        chk("t3_hs_stall", 128'(hs_cnt - h0), 128'(0));
        oif.out_ready = 1'b1;
        @(negedge clk);
        chk("t3_rel_valid", 128'(oif.out_valid), 128'(0));
        chk("t3_rel_hs",    128'(hs_cnt - h0), 128'(1));
        chk("t3_rel_v0",    128'(oif.out_v0), 128'(vfn(13'd100)));
        wait_idle("t3");
        chk("t3_done", 128'(done_cnt - d0), 128'(1));
        chk("t3_hs",   128'(hs_cnt - h0), 128'(1));

        // Instance with zero triangles is skipped
        set_inst(0, 13'd100, 12'd10, 13'd0, 12'd0, XF0);
        set_inst(1, 13'd300, 12'd8, 13'd20, 12'd1, XF1);
        d0 = done_cnt; h0 = hs_cnt;
        do_start(2);
        get_tri("t4", 13'd307, 13'd306, 13'd305, XF1, 8'd1);
        wait_idle("t4");
        chk("t4_hs",   128'(hs_cnt - h0), 128'(1));
        chk("t4_done", 128'(done_cnt - d0), 128'(1));

        // Zero instances
        d0 = done_cnt;
        do_start(0);
        chk("t5_busy_a", 128'({busy, done}), 128'(2'b10));
        @(negedge clk);
        chk("t5_busy_b", 128'({busy, done}), 128'(2'b01));
        @(negedge clk);
        chk("t5_busy_c", 128'({busy, done}), 128'(2'b00));
        chk("t5_done",   128'(done_cnt - d0), 128'(1));

        // Vertex address wrap
        set_inst(0, 13'd8190, 12'd8, 13'd30, 12'd1, XF0);
        do_start(1);
        get_tri("t6", 13'd1, 13'd8190, 13'd8191, XF0, 8'd0);
        wait_idle("t6");

        // Out-of-range index drops a triangle; index == count-1 is legal
        set_inst(0, 13'd500, 12'd4, 13'd40, 12'd2, XF1);
        h0 = hs_cnt;
        do_start(1);
        get_tri("t7", 13'd503, 13'd503, 13'd503, XF1, 8'd0);
        wait_idle("t7");
        chk("t7_hs",  128'(hs_cnt - h0), 128'(1));
        chk("t7_err", 128'(idx_err), 128'(1));
        repeat (5) @(negedge clk);
        chk("t7_err_sticky", 128'(idx_err), 128'(1));

        // Reset while fetching v1, then a clean walk
        set_inst(0, 13'd100, 12'd10, 13'd0, 12'd1, XF0);
        d0 = done_cnt;
        do_start(1);
        chk("t8_err_clr", 128'(idx_err), 128'(0));
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (vert_addr_rd === 13'd101) ok = 1'b1;
        end
        chk("t8_in_v1", 128'(ok), 128'(1));
        rst_raster_n = 1'b0;
        @(negedge clk);
        chk("t8_rst_ctl",  128'({busy, done, idx_err, oif.out_valid}), 128'(0));
        chk("t8_rst_addr", 128'({inst_id_rd, tri_addr_rd, vert_addr_rd}), 128'(0));
        chk("t8_rst_v01",  128'({oif.out_v0, oif.out_v1}), 128'(0));
        chk("t8_rst_v2xf", 128'({oif.out_v2, oif.out_transform, oif.out_inst_id}), 128'(0));
        rst_raster_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t8_no_done", 128'(done_cnt - d0), 128'(0));
        chk("t8_idle",    128'(busy), 128'(0));
        do_start(1);
        get_tri("t8b", 13'd100, 13'd101, 13'd102, XF0, 8'd0);
        wait_idle("t8b");
        chk("t8b_done", 128'(done_cnt - d0), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
